// File: rtl/axis_spm_offset_slewer.sv
// N-channel slew-rate-limited offset adjuster with global settle FSM, hold and output saturation.
// Optional modulation injection onto one channel is compiled in with SPM_OFFSET_MODULATION_EN.
//
// state     | meaning
// IDLE      | all channels at target; settled reports the last completed settle
// SLEWING   | at least one channel is still stepping towards its target
// SETTLING  | all channels arrived; counting settle ticks before flagging settled
module axis_spm_offset_slewer #(
    parameter int NCH      = 4,
    parameter int DW       = 32,
    parameter int RDECI    = 5,
    parameter int SETTLE_W = 8
) (
    input  logic                a_clk,
    input  logic                a_resetn,
    input  logic [NCH*DW-1:0]   S_AXIS_TARGET_tdata,
    input  logic                S_AXIS_TARGET_tvalid,
    input  logic [NCH*DW-1:0]   step,
    input  logic [SETTLE_W-1:0] settle_ticks,
    input  logic                hold,
    input  logic [DW-1:0]       modulation,
    input  logic [3:0]          mod_target,
    output logic [NCH*DW-1:0]   M_AXIS_OUT_tdata,
    output logic                M_AXIS_OUT_tvalid,
    output logic [NCH*DW-1:0]   M_AXIS_MON_tdata,
    output logic                M_AXIS_MON_tvalid,
    output logic [NCH-1:0]      busy,
    output logic                settled
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SLEWING  = 2'd1;
    localparam logic [1:0] ST_SETTLING = 2'd2;

    // Symmetric clamp: the most negative code is never produced.
    localparam logic signed [DW:0] SAT_MAX = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0] SAT_MIN = -SAT_MAX;

    function automatic logic [DW-1:0] sat(input logic signed [DW:0] v);
        logic [DW-1:0] r;
        if (v > SAT_MAX)      r = SAT_MAX[DW-1:0];
        else if (v < SAT_MIN) r = SAT_MIN[DW-1:0];
        else                  r = v[DW-1:0];
        return r;
    endfunction

    function automatic logic signed [DW:0] sext(input logic [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    logic                       tick;
    logic [NCH-1:0][DW-1:0]     tgt_q, tgt_eff, cur_q, cur_d, out_q, out_d;
    logic [NCH-1:0]             busy_q, busy_d;
    logic [1:0]                 state_q, state_d;
    logic                       settled_q, settled_d;
    logic [SETTLE_W-1:0]        scnt_q, scnt_d;
    logic                       valid_q;
    logic                       pending;
    logic signed [DW-1:0]       stp, up, dn, tgt_s;

    generate
        if (RDECI == 0) begin : g_tick_every
            assign tick = 1'b1;
        end else begin : g_tick_cnt
            logic [RDECI-1:0] tcnt_q;
            always_ff @(posedge a_clk or negedge a_resetn) begin
                if (!a_resetn) tcnt_q <= '0;
                else           tcnt_q <= tcnt_q + 1'b1;
            end
            assign tick = (tcnt_q == '0);
        end
    endgenerate

    // A target arriving this cycle is already visible to the adjuster.
    always_comb begin
        tgt_eff = S_AXIS_TARGET_tvalid ? S_AXIS_TARGET_tdata : tgt_q;
        cur_d   = cur_q;
        busy_d  = busy_q;
        pending = 1'b0;
        stp     = '0;
        up      = '0;
        dn      = '0;
        tgt_s   = '0;
        for (int k = 0; k < NCH; k++) begin
            stp     = step[k*DW +: DW];
            tgt_s   = tgt_eff[k];
            up      = sat(sext(cur_q[k]) + sext(stp));
            dn      = sat(sext(cur_q[k]) - sext(stp));
            pending = pending | (cur_q[k] != tgt_eff[k]);
            if (tick && !hold && !stp[DW-1] && (stp != '0)) begin
                if (tgt_s > up)      cur_d[k] = up;
                else if (tgt_s < dn) cur_d[k] = dn;
                else                 cur_d[k] = tgt_eff[k];
            end
            if (tick) busy_d[k] = (cur_d[k] != tgt_eff[k]);
        end
    end

    always_comb begin
        state_d   = state_q;
        settled_d = settled_q;
        scnt_d    = scnt_q;
        if (tick && !hold) begin
            case (state_q)
                ST_IDLE: begin
                    if (pending) begin
                        state_d   = ST_SLEWING;
                        settled_d = 1'b0;
                    end
                end
                ST_SLEWING: begin
                    settled_d = 1'b0;
                    if (busy_d == '0) begin
                        state_d = ST_SETTLING;
                        scnt_d  = settle_ticks;
                    end
                end
                ST_SETTLING: begin
                    if (pending) begin
                        state_d   = ST_SLEWING;
                        settled_d = 1'b0;
                    end else if (scnt_q <= SETTLE_W'(1)) begin
                        state_d   = ST_IDLE;
                        settled_d = 1'b1;
                        scnt_d    = '0;
                    end else begin
                        scnt_d = scnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef SPM_OFFSET_MODULATION_EN
    always_comb begin
        out_d = cur_q;
        for (int k = 0; k < NCH; k++) begin
            if (mod_target == 4'(k + 1)) out_d[k] = sat(sext(cur_q[k]) + sext(modulation));
        end
    end
`else
    logic unused_mod;
    assign unused_mod = ^{modulation, mod_target};
    assign out_d      = cur_q;
`endif

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            tgt_q     <= '0;
            cur_q     <= '0;
            out_q     <= '0;
            busy_q    <= '0;
            state_q   <= ST_IDLE;
            settled_q <= 1'b0;
            scnt_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            tgt_q     <= tgt_eff;
            cur_q     <= cur_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            state_q   <= state_d;
            settled_q <= settled_d;
            scnt_q    <= scnt_d;
            valid_q   <= 1'b1;
        end
    end

    assign M_AXIS_OUT_tdata  = out_q;
    assign M_AXIS_MON_tdata  = cur_q;
    assign M_AXIS_OUT_tvalid = valid_q;
    assign M_AXIS_MON_tvalid = valid_q;
    assign busy              = busy_q;
    assign settled           = settled_q;

endmodule

// File: tb/tb_axis_spm_offset_slewer.sv
// Directed bench for axis_spm_offset_slewer with RDECI = 2 (one tick every 4 clocks).
// Expectations for the modulation path follow SPM_OFFSET_MODULATION_EN.
module tb_axis_spm_offset_slewer;

    localparam int NCH      = 4;
    localparam int DW       = 32;
    localparam int RDECI    = 2;
    localparam int SETTLE_W = 8;

    logic                a_clk = 1'b0;
    logic                a_resetn = 1'b0;
    logic [NCH*DW-1:0]   tgt_data = '0;
    logic                tgt_valid = 1'b0;
    logic [NCH*DW-1:0]   step_v = '0;
    logic [SETTLE_W-1:0] settle_ticks = '0;
    logic                hold = 1'b0;
    logic [DW-1:0]       modulation = '0;
    logic [3:0]          mod_target = '0;
    logic [NCH*DW-1:0]   out_data, mon_data;
    logic                out_valid, mon_valid, settled;
    logic [NCH-1:0]      busy;

    logic [NCH*DW-1:0]   tgt_v = '0;
    logic [DW-1:0]       exp_v;
    int                  checks = 0;
    int                  errors = 0;
    int                  cyc;

    axis_spm_offset_slewer #(
        .NCH(NCH), .DW(DW), .RDECI(RDECI), .SETTLE_W(SETTLE_W)
    ) dut (
        .a_clk               (a_clk),
        .a_resetn            (a_resetn),
        .S_AXIS_TARGET_tdata (tgt_data),
        .S_AXIS_TARGET_tvalid(tgt_valid),
        .step                (step_v),
        .settle_ticks        (settle_ticks),
        .hold                (hold),
        .modulation          (modulation),
        .mod_target          (mod_target),
        .M_AXIS_OUT_tdata    (out_data),
        .M_AXIS_OUT_tvalid   (out_valid),
        .M_AXIS_MON_tdata    (mon_data),
        .M_AXIS_MON_tvalid   (mon_valid),
        .busy                (busy),
        .settled             (settled)
    );

    always #5 a_clk = ~a_clk;

    // Edge n after reset release is a tick edge when (n-1) % 4 == 0.
    always @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mon(input int k);
        return mon_data[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] outv(input int k);
        return out_data[k*DW +: DW];
    endfunction

    task automatic next_tick();
        do begin
            @(posedge a_clk);
            #1;
        end while (cyc % 4 != 1);
    endtask

    task automatic load_targets();
        tgt_data  = tgt_v;
        tgt_valid = 1'b1;
        @(posedge a_clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    initial begin
        step_v[0*DW +: DW] = 32'd100;
        step_v[1*DW +: DW] = 32'h7FFFFFFF;
        step_v[2*DW +: DW] = 32'h40000000;
        step_v[3*DW +: DW] = 32'd10;
        settle_ticks       = 8'd3;

        #12;
        check_eq("rst_mon", mon_data, '0);
        check_eq("rst_out", out_data, '0);
        check_eq("rst_valid", {out_valid, mon_valid}, 2'b00);
        check_eq("rst_busy", busy, '0);
        check_eq("rst_settled", settled, 1'b0);
        #10 a_resetn = 1'b1;
        @(posedge a_clk);
        #1;
        check_eq("valid_after_rst", {out_valid, mon_valid}, 2'b11);

        // Ramp ch0 0 -> 1000 in steps of 100, then settle for 3 ticks.
        tgt_v[0*DW +: DW] = 32'd1000;
        load_targets();
        for (int i = 1; i <= 10; i++) begin
            next_tick();
            check_eq("t1_ramp", mon(0), 64'(100 * i));
            check_eq("t1_busy", busy[0], (i < 10));
        end
        check_eq("t1_out_lag", outv(0), 32'd900);
        @(posedge a_clk);
        #1;
        check_eq("t1_out", outv(0), 32'd1000);
        for (int i = 1; i <= 3; i++) begin
            next_tick();
            check_eq("t1_settled", settled, (i == 3));
        end

        // Approach positive full scale without wrapping.
        tgt_v[1*DW +: DW] = 32'h7FFFFF00;
        load_targets();
        next_tick();
        check_eq("t2_preset", mon(1), 32'h7FFFFF00);
        step_v[1*DW +: DW] = 32'h00000100;
        tgt_v[1*DW +: DW]  = 32'h7FFFFFF0;
        load_targets();
        next_tick();
        check_eq("t2_mon", mon(1), 32'h7FFFFFF0);
        check_eq("t2_busy", busy[1], 1'b0);
        @(posedge a_clk);
        #1;
        check_eq("t2_out", outv(1), 32'h7FFFFFF0);

        // Large negative step saturates at -(2^31-1).
        tgt_v[2*DW +: DW] = 32'h80000001;
        load_targets();
        next_tick();
        check_eq("t3_step1", mon(2), 32'hC0000000);
        next_tick();
        check_eq("t3_step2", mon(2), 32'h80000001);
        next_tick();
        check_eq("t3_hold_sat", mon(2), 32'h80000001);
        check_eq("t3_busy", busy[2], 1'b0);
        repeat (10) next_tick();
        check_eq("quiet_settled", settled, 1'b1);

        // New target during SETTLING restarts slewing and the settle count.
        settle_ticks      = 8'd5;
        tgt_v[0*DW +: DW] = 32'd1100;
        load_targets();
        for (int t = 1; t <= 13; t++) begin
            next_tick();
            if (t == 3) begin
                tgt_v[3*DW +: DW] = 32'd50;
                load_targets();
            end
            check_eq("t4_settled", settled, (t == 13));
            if (t == 4) check_eq("t4_ch3_first", mon(3), 32'd10);
            if (t == 8) begin
                check_eq("t4_ch3_arrive", mon(3), 32'd50);
                check_eq("t4_busy3", busy[3], 1'b0);
            end
        end

        // Hold freezes the ramp; a capture under hold lands afterwards.
        tgt_v[0*DW +: DW] = 32'd2100;
        load_targets();
        for (int i = 1; i <= 3; i++) begin
            next_tick();
            check_eq("t5_ramp", mon(0), 64'(1100 + 100 * i));
        end
        hold = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            next_tick();
            check_eq("t5_hold", mon(0), 32'd1400);
            if (i == 4) begin
                tgt_v[0*DW +: DW] = 32'd1500;
                load_targets();
            end
        end
        check_eq("t5_hold_settled", settled, 1'b0);
        hold = 1'b0;
        next_tick();
        check_eq("t5_resume", mon(0), 32'd1500);
        check_eq("t5_busy", busy[0], 1'b0);
        for (int i = 1; i <= 5; i++) begin
            next_tick();
            check_eq("t5_settled", settled, (i == 5));
        end

        // Modulation injection on ch1.
        mod_target = 4'd2;
        modulation = 32'h00000100;
        @(posedge a_clk);
        #1;
`ifdef SPM_OFFSET_MODULATION_EN
        exp_v = 32'h7FFFFFFF;
`else
        exp_v = 32'h7FFFFFF0;
`endif
        check_eq("t6_out_sat", outv(1), exp_v);
        step_v[1*DW +: DW] = 32'h7FFFFFFF;
        tgt_v[1*DW +: DW]  = 32'd1000;
        load_targets();
        next_tick();
        check_eq("t6_mon_pre", mon(1), 32'd1000);
        modulation = 32'hFFFFFE0C;
        @(posedge a_clk);
        #1;
`ifdef SPM_OFFSET_MODULATION_EN
        exp_v = 32'd500;
`else
        exp_v = 32'd1000;
`endif
        check_eq("t6_out_mod", outv(1), exp_v);
        check_eq("t6_mon_raw", mon(1), 32'd1000);
        check_eq("t6_out_ch0", outv(0), 32'd1500);
        mod_target = 4'd7;
        @(posedge a_clk);
        #1;
        check_eq("t6_out_none", outv(1), 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_spm_offset_slewer.md
Name: axis_spm_offset_slewer

Overview:
N-channel slew-rate-limited offset adjuster for SPM scan/bias offsets (X0, Y0, Z0, U0, ...).
- Generalises the fixed XYZ per-axis adjusters to a parametrised channel count and width.
- Adds per-channel step limits, a global settle state machine, a hold input, saturation and optional modulation injection.
- Sits between the PS register bank and the DAC mixing/rotation stage; outputs feed the final position sum.

Parameters:
NCH, 4, number of offset channels.
DW, 32, signed data width per channel (Q31 full scale).
RDECI, 5, update tick every 2^RDECI a_clk cycles.
SETTLE_W, 8, width of the settle-tick counter.

Ports:
a_clk  in  1  clock.
a_resetn  in  1  asynchronous active-low reset.
S_AXIS_TARGET_tdata  in  NCH*DW  packed signed targets; channel k at [k*DW +: DW].
S_AXIS_TARGET_tvalid  in  1  capture strobe for targets.
step  in  NCH*DW  packed signed max step per tick, per channel.
settle_ticks  in  SETTLE_W  ticks to wait after all channels arrive.
hold  in  1  freeze adjusters and settle counter.
modulation  in  DW  signed modulation sample.
mod_target  in  4  0 = none; k = add modulation to channel k-1; values > NCH = none.
M_AXIS_OUT_tdata  out  NCH*DW  saturated offset plus modulation.
M_AXIS_OUT_tvalid  out  1  constant 1 after reset release.
M_AXIS_MON_tdata  out  NCH*DW  raw offsets, unmodulated.
M_AXIS_MON_tvalid  out  1  constant 1 after reset release.
busy  out  NCH  channel k is not yet at its target.
settled  out  1  FSM is in IDLE after completing a settle.

Behaviour:
Reset (a_resetn = 0, asynchronous):
- Offsets, targets, outputs, busy, settled, tick counter and settle counter clear to 0.
- FSM goes to IDLE.
- Both tvalid outputs are 0 during reset and 1 from the first a_clk after release.

Target capture:
- Targets are captured on any a_clk where tvalid = 1, independent of tick.
- Capture is sampled before the adjuster update in the same cycle.

Tick:
- An RDECI-bit free-running counter asserts tick for one cycle when it equals 0.
- RDECI = 0 means tick on every cycle.

Adjuster, per channel, on tick and hold = 0:
- Compute p = cur + step and m = cur - step in DW+1 bits.
- If target > p: cur <= p. Else if target < m: cur <= m. Else: cur <= target.
- p and m saturate to ±(2^(DW-1) - 1) before assignment, so no wrap-around.
- step <= 0: channel frozen, cur unchanged.
- busy[k] = (cur != target), registered on each tick.

FSM, advancing on tick only:
- IDLE: any busy -> SLEWING; settled holds its last value.
- SLEWING: settled = 0; when busy == 0 -> SETTLING, counter <= settle_ticks.
- SETTLING: counter decrements; when it reaches 0 -> IDLE with settled = 1.
- SETTLING with settle_ticks = 0: go to IDLE on the next tick.
- A new target that sets any busy bit while in SETTLING or IDLE -> SLEWING, settled = 0.
- A capture identical to the current offsets does not leave IDLE.

hold = 1:
- No offset updates; FSM and settle counter frozen.
- Targets are still captured and outputs still refresh.

Outputs:
- out[k] = SAT(cur[k] + (mod_target == k+1 ? modulation : 0)), computed in DW+1 bits and saturated to ±(2^(DW-1) - 1).
- Registered every a_clk cycle: 1-cycle latency from a cur or modulation change.
- MON equals cur directly, no added latency.

Optional Feature:
SPM_OFFSET_MODULATION_EN
- Defined: modulation adder and mod_target decode are present, as described above.
- Undefined: out = cur registered with 1-cycle latency; modulation and mod_target are ignored and no adder is synthesised.

Test Plan:
All scenarios use NCH = 4, DW = 32, RDECI = 2 (tick every 4 cycles).
1. Reset release, target ch0 = 1000, step = 100, settle_ticks = 3 -> ch0 ramps 100, 200, ... 1000 over 10 ticks; busy[0] falls on tick 10; settled rises 3 ticks later.
2. Target ch1 = 0x7FFFFFF0 from 0x7FFFFF00, step = 0x100 -> output is 0x7FFFFFF0 after 1 tick; no wrap; busy[1] clears.
3. Target ch2 = -0x7FFFFFFF, step = 0x40000000, start 0 -> ch2 steps -0x40000000, -0x7FFFFFFF (saturated), holds; no positive value ever appears.
4. Start settle on ch0 (settle_ticks = 5), then during SETTLING target ch3 = 50 -> FSM returns to SLEWING; settled stays 0 until ch3 arrives plus 5 ticks.
5. hold = 1 mid-ramp for 8 ticks -> ch0 value unchanged throughout; ramp resumes from the same value after hold = 0.
6. (Macro defined) mod_target = 2, modulation = -500, ch1 = 1000 -> out[1] = 500 one cycle later, MON[1] = 1000; mod_target = 7 -> out[1] = 1000.
